// File: rtl/dadda_mult_pipe.sv
// Pipelined unsigned WIDTH x WIDTH Dadda multiplier with per-transaction exact/approximate mode,
// valid/ready handshake on both sides, overflow flag and saturating overflow-event counter.
module dadda_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int APPROX_COLS = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_hi,
  output logic               overflow,
  output logic               mode_out,
  input  logic               clr_count,
  output logic [CNT_W-1:0]   ovf_count
);

  localparam int P = 2 * WIDTH;

  logic             adv_s;
  logic [2*P-1:0]   last_cs_s;
  logic             last_md_s;
  logic             last_vld_s;
  logic [P-1:0]     prod_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_hi_r;
  logic             overflow_r;
  logic             mode_out_r;
  logic [CNT_W-1:0] ovf_count_r;

  // Dadda reduction of the partial-product rows down to {carry, sum}. Approximate mode masks the
  // low columns out of the exact sum and ORs them into the sum row; those columns never carry.
  function automatic logic [2*P-1:0] dadda_cs(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             approx);
    logic [P-1:0] rows [WIDTH];
    logic [P-1:0] nxt  [WIDTH];
    logic [P-1:0] mask;
    logic [P-1:0] low;
    int n, d, k, m;
    mask = approx ? ({P{1'b1}} << APPROX_COLS) : {P{1'b1}};
    low  = '0;
    for (int j = 0; j < WIDTH; j++) begin
      rows[j] = ({{WIDTH{1'b0}}, a & {WIDTH{b[j]}}} << j) & mask;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (approx && (i + j < APPROX_COLS)) begin
          low[i+j] = low[i+j] | (a[i] & b[j]);
        end
      end
    end
    n = WIDTH;
    for (int layer = 0; layer < WIDTH; layer++) begin
      if (n > 2) begin
        // Target height is the largest Dadda number (2,3,4,6,9,13,...) below the current height.
        d = 2;
        for (int t = 0; t < 12; t++) begin
          if ((d * 3) / 2 < n) d = (d * 3) / 2;
        end
        k = n - d;
        m = 0;
        for (int i = 0; i < WIDTH; i++) nxt[i] = '0;
        for (int c = 0; c < WIDTH; c++) begin
          if (c < k) begin
            nxt[m]   = rows[3*c] ^ rows[3*c+1] ^ rows[3*c+2];
            nxt[m+1] = ((rows[3*c] & rows[3*c+1]) | (rows[3*c] & rows[3*c+2]) |
                        (rows[3*c+1] & rows[3*c+2])) << 1;
            m = m + 2;
          end
        end
        for (int i = 0; i < WIDTH; i++) begin
          if ((i >= 3 * k) && (i < n)) begin
            nxt[m] = rows[i];
            m = m + 1;
          end
        end
        rows = nxt;
        n = d;
      end
    end
    return {rows[1], rows[0] | low};
  endfunction

  assign adv_s    = !out_valid_r || out_ready;
  assign in_ready = adv_s;

  generate
    if (STAGES == 1) begin : g_comb
      // Single stage: reduction and final adder both feed the output register.
      always_comb begin
        last_cs_s  = dadda_cs(in1, in2, mode);
        last_md_s  = mode;
        last_vld_s = in_valid;
      end
    end else begin : g_pipe
      logic [2*P-1:0]  cs_r [STAGES-1];
      logic [STAGES-2:0] md_r;
      logic [STAGES-2:0] vld_r;

      // Reduction result registered at the first cut, then carried in carry-save form.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < STAGES - 1; s++) cs_r[s] <= '0;
          md_r  <= '0;
          vld_r <= '0;
        end else if (adv_s) begin
          cs_r[0]  <= dadda_cs(in1, in2, mode);
          md_r[0]  <= mode;
          vld_r[0] <= in_valid;
          for (int s = 1; s < STAGES - 1; s++) begin
            cs_r[s]  <= cs_r[s-1];
            md_r[s]  <= md_r[s-1];
            vld_r[s] <= vld_r[s-1];
          end
        end
      end

      assign last_cs_s  = cs_r[STAGES-2];
      assign last_md_s  = md_r[STAGES-2];
      assign last_vld_s = vld_r[STAGES-2];
    end
  endgenerate

  assign prod_s = last_cs_s[2*P-1:P] + last_cs_s[P-1:0];

  // Output register: loads only on a valid slot so results persist through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_r       <= '0;
      out_hi_r    <= '0;
      overflow_r  <= 1'b0;
      mode_out_r  <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= last_vld_s;
      if (last_vld_s) begin
        out_r      <= prod_s[WIDTH-1:0];
        out_hi_r   <= prod_s[P-1:WIDTH];
        overflow_r <= |prod_s[P-1:WIDTH];
        mode_out_r <= last_md_s;
      end
    end
  end

  // Saturating count of delivered overflow results; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_r <= '0;
    end else if (clr_count) begin
      ovf_count_r <= '0;
    end else if (out_valid_r && out_ready && overflow_r && (ovf_count_r != {CNT_W{1'b1}})) begin
      ovf_count_r <= ovf_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign out_hi    = out_hi_r;
  assign overflow  = overflow_r;
  assign mode_out  = mode_out_r;
  assign ovf_count = ovf_count_r;

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Scoreboard bench: an 8-bit 2-stage instance (2-bit counter) and a 4-bit 1-stage instance
// checked against an independent column-wise reference model.
module tb_dadda_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       v8, ir8, m8, ov8, ordy8, clr8, ovf8, mo8;
  logic [7:0] a8, b8, lo8, hi8;
  logic [1:0] cnt8;
  logic       v4, ir4, m4, ov4, ordy4, clr4, ovf4, mo4;
  logic [3:0] a4, b4, lo4, hi4;
  logic [15:0] cnt4;

  dadda_mult_pipe #(.WIDTH(8), .STAGES(2), .APPROX_COLS(4), .CNT_W(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in1(a8), .in2(b8), .mode(m8),
    .out_valid(ov8), .out_ready(ordy8), .out(lo8), .out_hi(hi8), .overflow(ovf8),
    .mode_out(mo8), .clr_count(clr8), .ovf_count(cnt8));

  dadda_mult_pipe #(.WIDTH(4), .STAGES(1), .APPROX_COLS(3), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in1(a4), .in2(b4), .mode(m4),
    .out_valid(ov4), .out_ready(ordy4), .out(lo4), .out_hi(hi4), .overflow(ovf4),
    .mode_out(mo4), .clr_count(clr4), .ovf_count(cnt4));

  int n_tests = 0;
  int n_fail  = 0;
  int ovf4_exp = 0;
  logic [64:0] q8[$];
  logic [64:0] q4[$];
  logic        st_prev;
  logic [7:0]  lo_prev, hi_prev;
  logic        ovf_prev, mo_prev;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact product, or OR-only low columns plus carry-free column sums above them.
  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                           input logic m, input int w, input int ac);
    logic [63:0] r;
    logic [63:0] lo;
    r  = 64'd0;
    lo = 64'd0;
    if (!m) return {32'd0, a} * {32'd0, b};
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++)
        if (a[i] & b[j]) begin
          if (i + j < ac) lo[i+j] = 1'b1;
          else r = r + (64'd1 << (i + j));
        end
    return r | lo;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (st_prev) begin
        check_eq("stall_valid", {63'd0, ov8}, 64'd1);
        check_eq("stall_lo", {56'd0, lo8}, {56'd0, lo_prev});
        check_eq("stall_hi", {56'd0, hi8}, {56'd0, hi_prev});
        check_eq("stall_ovf", {63'd0, ovf8}, {63'd0, ovf_prev});
        check_eq("stall_mode", {63'd0, mo8}, {63'd0, mo_prev});
      end
      if (ov8 && !ordy8) check_eq("stall_in_ready", {63'd0, ir8}, 64'd0);
      if (ov8 && ordy8) begin
        if (q8.size() == 0) check_eq("sb8_spurious", {63'd0, ov8}, 64'd0);
        else begin
          check_eq("sb8_lo", {56'd0, lo8}, {56'd0, q8[0][7:0]});
          check_eq("sb8_hi", {56'd0, hi8}, {56'd0, q8[0][15:8]});
          check_eq("sb8_ovf", {63'd0, ovf8}, {63'd0, |q8[0][15:8]});
          check_eq("sb8_mode", {63'd0, mo8}, {63'd0, q8[0][64]});
          void'(q8.pop_front());
        end
      end
      if (v8 && ir8) q8.push_back({m8, ref_mult({24'd0, a8}, {24'd0, b8}, m8, 8, 4)});
      st_prev  <= ov8 && !ordy8;
      lo_prev  <= lo8;
      hi_prev  <= hi8;
      ovf_prev <= ovf8;
      mo_prev  <= mo8;
    end else begin
      st_prev <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov4 && ordy4) begin
        if (q4.size() == 0) check_eq("sb4_spurious", {63'd0, ov4}, 64'd0);
        else begin
          check_eq("sb4_lo", {60'd0, lo4}, {60'd0, q4[0][3:0]});
          check_eq("sb4_hi", {60'd0, hi4}, {60'd0, q4[0][7:4]});
          check_eq("sb4_ovf", {63'd0, ovf4}, {63'd0, |q4[0][7:4]});
          check_eq("sb4_mode", {63'd0, mo4}, {63'd0, q4[0][64]});
          if (|q4[0][7:4]) ovf4_exp++;
          void'(q4.pop_front());
        end
      end
      if (v4 && ir4) q4.push_back({m4, ref_mult({28'd0, a4}, {28'd0, b4}, m4, 4, 3)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the operands.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic m);
    int g;
    logic acc;
    g = 0;
    a8 = a; b8 = b; m8 = m; v8 = 1'b1;
    do begin
      @(negedge clk);
      acc = ir8;
      g++;
    end while (!acc && g < 100);
    if (!acc) check_eq("send8_timeout", {63'd0, acc}, 64'd1);
    tick();
    v8 = 1'b0;
  endtask

  task automatic drain(input int which);
    int g;
    g = 0;
    while (((which == 8) ? q8.size() : q4.size()) != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain", 64'(((which == 8) ? q8.size() : q4.size())), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v8 = 1'b0; a8 = 8'd0; b8 = 8'd0; m8 = 1'b0; ordy8 = 1'b1; clr8 = 1'b0;
    v4 = 1'b0; a4 = 4'd0; b4 = 4'd0; m4 = 1'b0; ordy4 = 1'b1; clr4 = 1'b0;
    st_prev = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", {63'd0, ov8}, 64'd0);
    check_eq("rst_lo", {56'd0, lo8}, 64'd0);
    check_eq("rst_hi", {56'd0, hi8}, 64'd0);
    check_eq("rst_ovf", {63'd0, ovf8}, 64'd0);
    check_eq("rst_mode", {63'd0, mo8}, 64'd0);
    check_eq("rst_cnt", {62'd0, cnt8}, 64'd0);
    check_eq("rst_valid4", {63'd0, ov4}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", {63'd0, ir8}, 64'd1);

    // Directed products with latency check.
    send8(8'h0F, 8'h0F, 1'b0);
    @(negedge clk); check_eq("lat_early", {63'd0, ov8}, 64'd0);
    @(negedge clk); check_eq("lat_valid", {63'd0, ov8}, 64'd1);
    check_eq("e_0f_lo", {56'd0, lo8}, 64'hE1);
    check_eq("e_0f_hi", {56'd0, hi8}, 64'h00);
    check_eq("e_0f_ovf", {63'd0, ovf8}, 64'd0);
    tick();
    send8(8'h0F, 8'h0F, 1'b1);
    @(negedge clk); @(negedge clk);
    check_eq("a_0f_lo", {56'd0, lo8}, 64'hBF);
    check_eq("a_0f_hi", {56'd0, hi8}, 64'h00);
    check_eq("a_0f_mode", {63'd0, mo8}, 64'd1);
    tick();
    send8(8'hFF, 8'hFF, 1'b0);
    @(negedge clk); @(negedge clk);
    check_eq("e_ff_lo", {56'd0, lo8}, 64'h01);
    check_eq("e_ff_hi", {56'd0, hi8}, 64'hFE);
    check_eq("e_ff_ovf", {63'd0, ovf8}, 64'd1);
    tick();
    @(negedge clk); check_eq("cnt_first", {62'd0, cnt8}, 64'd1);
    tick();

    // Counter saturation and clear priority.
    clr8 = 1'b1; tick(); clr8 = 1'b0;
    @(negedge clk); check_eq("cnt_clr", {62'd0, cnt8}, 64'd0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      send8(8'h80 + 8'(k), 8'h10, 1'b0);
      @(negedge clk); @(negedge clk);
      tick();
      @(negedge clk);
      check_eq("cnt_sat", {62'd0, cnt8}, (k < 3) ? 64'(k) : 64'd3);
      tick();
    end
    send8(8'hFF, 8'hFF, 1'b0);
    @(negedge clk); @(negedge clk);
    clr8 = 1'b1; tick(); clr8 = 1'b0;
    @(negedge clk); check_eq("cnt_clr_prio", {62'd0, cnt8}, 64'd0);
    tick();

    // Random stream with a four-cycle output stall.
    fork
      begin
        for (int k = 0; k < 8; k++)
          send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(posedge clk);
        #1 ordy8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 ordy8 = 1'b1;
      end
    join
    drain(8);

    // Reset with two transactions in flight.
    send8(8'h03, 8'h05, 1'b0);
    send8(8'h07, 8'h09, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {63'd0, ov8}, 64'd0);
    check_eq("mid_rst_lo", {56'd0, lo8}, 64'd0);
    check_eq("mid_rst_hi", {56'd0, hi8}, 64'd0);
    check_eq("mid_rst_mode", {63'd0, mo8}, 64'd0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check_eq("post_rst_idle", {63'd0, ov8}, 64'd0);
    send8(8'h12, 8'h34, 1'b0);
    @(negedge clk); check_eq("post_rst_early", {63'd0, ov8}, 64'd0);
    @(negedge clk);
    check_eq("post_rst_valid", {63'd0, ov8}, 64'd1);
    check_eq("post_rst_lo", {56'd0, lo8}, 64'hA8);
    check_eq("post_rst_hi", {56'd0, hi8}, 64'h03);
    drain(8);

    // Exhaustive 4-bit sweep in both modes, single stage.
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          a4 = 4'(a); b4 = 4'(b); m4 = 1'(m); v4 = 1'b1;
          tick();
        end
    v4 = 1'b0;
    drain(4);
    check_eq("cnt4_total", {48'd0, cnt4}, 64'(ovf4_exp));
    a4 = 4'hF; b4 = 4'h1; m4 = 1'b0; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    @(negedge clk);
    check_eq("w4_valid", {63'd0, ov4}, 64'd1);
    check_eq("w4_lo", {60'd0, lo4}, 64'hF);
    check_eq("w4_ovf", {63'd0, ovf4}, 64'd0);
    drain(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
